// File: rtl/mandelbrot_scan.sv
// ============================================================================
//  Module   : mandelbrot_scan
//  Purpose  : Raster-order coordinate issuer and result-to-framebuffer writer
//             for a pipelined Mandelbrot iterator. Optional palette mapping
//             is enabled by defining MANDELBROT_SCAN_PALETTE_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mandelbrot_scan #(
  parameter logic [10:0] RESX = 11'd64,
  parameter logic [10:0] RESY = 11'd48,
  parameter logic [15:0] IMAX = 16'd15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        frame_done,
  input  logic        next_in,
  output logic [10:0] xin,
  output logic [10:0] yin,
  input  logic        next_out,
  input  logic [10:0] xout,
  input  logic [10:0] yout,
  input  logic [15:0] i,
  output logic        wr_en,
  output logic [21:0] wr_addr,
  output logic [7:0]  wr_data
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [10:0] c_sentinel = 11'h7FF;
  localparam logic [10:0] c_xlast    = RESX - 11'd1;
  localparam logic [10:0] c_ylast    = RESY - 11'd1;
  localparam logic [21:0] c_total    = 22'(RESX) * 22'(RESY);

  state_t      r_state, w_state_nxt;
  logic [10:0] r_x, r_y, w_x_nxt, w_y_nxt;
  logic [21:0] r_done_cnt, w_cnt_inc, w_cnt_nxt;
  logic        r_wr_en;
  logic [21:0] r_wr_addr;
  logic [7:0]  r_wr_data;

  logic        w_accept, w_counting, w_last_issue;
  logic [21:0] w_addr;
  logic [7:0]  w_pix;

  always_comb begin
    w_accept     = next_out && (xout < RESX) && (yout < RESY);
    w_counting   = w_accept && ((r_state == ST_ISSUE) || (r_state == ST_DRAIN));
    w_cnt_inc    = r_done_cnt + {21'd0, w_counting};
    w_last_issue = (r_x == c_xlast) && (r_y == c_ylast);
    w_addr       = 22'(yout) * 22'(RESX) + 22'(xout);
`ifdef MANDELBROT_SCAN_PALETTE_EN
    w_pix = (i >= IMAX) ? 8'h00 : {i[2:0], i[5:3], i[7:6]};
`else
    w_pix = (i > 16'd255) ? 8'hFF : i[7:0];
`endif
  end

  // Next-state logic; completion by count overrides the issue->drain step.
  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_cnt_nxt   = w_cnt_inc;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_ISSUE;
          w_x_nxt     = 11'd0;
          w_y_nxt     = 11'd0;
          w_cnt_nxt   = 22'd0;
        end
      end
      ST_ISSUE: begin
        if (next_in) begin
          if (w_last_issue) begin
            w_state_nxt = ST_DRAIN;
          end else if (r_x == c_xlast) begin
            w_x_nxt = 11'd0;
            w_y_nxt = r_y + 11'd1;
          end else begin
            w_x_nxt = r_x + 11'd1;
          end
        end
        if (w_cnt_inc == c_total) w_state_nxt = ST_DONE;
      end
      ST_DRAIN: begin
        if (w_cnt_inc == c_total) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_x        <= 11'd0;
      r_y        <= 11'd0;
      r_done_cnt <= 22'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_x        <= w_x_nxt;
      r_y        <= w_y_nxt;
      r_done_cnt <= w_cnt_nxt;
    end
  end

  // Results are written in any state, even when they are not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= 22'd0;
      r_wr_data <= 8'd0;
    end else begin
      r_wr_en <= w_accept;
      if (w_accept) begin
        r_wr_addr <= w_addr;
        r_wr_data <= w_pix;
      end
    end
  end

  assign busy       = (r_state != ST_IDLE);
  assign frame_done = (r_state == ST_DONE);
  assign xin        = (r_state == ST_ISSUE) ? r_x : c_sentinel;
  assign yin        = (r_state == ST_ISSUE) ? r_y : c_sentinel;
  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;

endmodule

`default_nettype wire

// File: tb/tb_mandelbrot_scan.sv
// ============================================================================
//  Module   : tb_mandelbrot_scan
//  Purpose  : Directed self-checking bench for mandelbrot_scan (4x2 frame).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mandelbrot_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy;
  logic        frame_done;
  logic        next_in;
  logic [10:0] xin, yin;
  logic        next_out;
  logic [10:0] xout, yout;
  logic [15:0] i;
  logic        wr_en;
  logic [21:0] wr_addr;
  logic [7:0]  wr_data;

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] r_ivec [8];
  logic [7:0]  r_exp2 [8];
  logic [7:0]  r_exp3;

  mandelbrot_scan #(
    .RESX(11'd4),
    .RESY(11'd2),
    .IMAX(16'd15)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy),
    .frame_done (frame_done),
    .next_in    (next_in),
    .xin        (xin),
    .yin        (yin),
    .next_out   (next_out),
    .xout       (xout),
    .yout       (yout),
    .i          (i),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    r_ivec = '{16'd15, 16'd9, 16'd300, 16'd0, 16'd255, 16'd1, 16'd2, 16'd3};
`ifdef MANDELBROT_SCAN_PALETTE_EN
    r_exp2 = '{8'h00, 8'h24, 8'h00, 8'h00, 8'h00, 8'h20, 8'h40, 8'h60};
    r_exp3 = 8'h60;
`else
    r_exp2 = '{8'h0F, 8'h09, 8'hFF, 8'h00, 8'hFF, 8'h01, 8'h02, 8'h03};
    r_exp3 = 8'h03;
`endif

    rst_n = 1'b0; start = 1'b0; next_in = 1'b0; next_out = 1'b0;
    xout = 11'd0; yout = 11'd0; i = 16'd0;
    #3;
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(frame_done), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_addr",  32'(wr_addr), 32'd0);
    chk("rst_data",  32'(wr_data), 32'd0);
    chk("rst_xin",   32'(xin), 32'h7FF);
    chk("rst_yin",   32'(yin), 32'h7FF);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Frame 1: raster issue with a stray start mid-frame.
    start = 1'b1;
    tick();
    start = 1'b0;
    next_in = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("iss_xin",  32'(xin), 32'(k % 4));
      chk("iss_yin",  32'(yin), 32'(k / 4));
      chk("iss_busy", 32'(busy), 32'd1);
      start = (k == 2);
      tick();
    end
    start = 1'b0;
    chk("drain_xin", 32'(xin), 32'h7FF);
    chk("drain_yin", 32'(yin), 32'h7FF);
    tick();
    chk("drain_hold_xin", 32'(xin), 32'h7FF);
    chk("drain_busy",     32'(busy), 32'd1);
    next_in = 1'b0;

    // Sentinel and out-of-range results are discarded.
    next_out = 1'b1; xout = 11'h7FF; yout = 11'h7FF; i = 16'd3;
    tick();
    chk("sent_wr_en", 32'(wr_en), 32'd0);
    chk("sent_busy",  32'(busy), 32'd1);
    xout = 11'd4; yout = 11'd0;
    tick();
    chk("oor_wr_en", 32'(wr_en), 32'd0);

    // Results in reverse raster order.
    for (int a = 7; a >= 0; a--) begin
      xout = 11'(a % 4); yout = 11'(a / 4); i = 16'd3;
      tick();
      chk("rev_wr_en", 32'(wr_en), 32'd1);
      chk("rev_addr",  32'(wr_addr), 32'(a));
      chk("rev_data",  32'(wr_data), 32'(r_exp3));
      chk("rev_done",  32'(frame_done), (a == 0) ? 32'd1 : 32'd0);
    end
    next_out = 1'b0;
    tick();
    chk("f1_done_clr", 32'(frame_done), 32'd0);
    chk("f1_busy_clr", 32'(busy), 32'd0);
    chk("f1_wr_clr",   32'(wr_en), 32'd0);

    // Frame 2: abandoned by reset after three issued pixels.
    start = 1'b1;
    tick();
    start = 1'b0;
    next_in = 1'b1;
    tick(); tick(); tick();
    chk("pre_rst_xin", 32'(xin), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_xin",  32'(xin), 32'h7FF);
    next_in = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // In-range result while idle: written, not counted.
    next_out = 1'b1; xout = 11'd1; yout = 11'd1; i = 16'd5;
    tick();
    chk("idle_wr_en", 32'(wr_en), 32'd1);
    chk("idle_addr",  32'(wr_addr), 32'd5);
    chk("idle_busy",  32'(busy), 32'd0);
    next_out = 1'b0;

    // Frame 3: fresh start, full issue, forward results with varied counts.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("f3_xin", 32'(xin), 32'd0);
    chk("f3_yin", 32'(yin), 32'd0);
    next_in = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    next_in = 1'b0;
    chk("f3_drain_xin", 32'(xin), 32'h7FF);
    next_out = 1'b1;
    for (int a = 0; a < 8; a++) begin
      xout = 11'(a % 4); yout = 11'(a / 4); i = r_ivec[a];
      tick();
      chk("f3_addr", 32'(wr_addr), 32'(a));
      chk("f3_data", 32'(wr_data), 32'(r_exp2[a]));
      chk("f3_done", 32'(frame_done), (a == 7) ? 32'd1 : 32'd0);
    end
    next_out = 1'b0;
    tick();
    chk("f3_busy_clr", 32'(busy), 32'd0);
    chk("f3_done_clr", 32'(frame_done), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mandelbrot_scan.md
MANDELBROT_SCAN -- requirements
Module: mandelbrot_scan

Interface
REQ-001 SHALL have parameter RESX, default 11'd64, frame width in pixels (legal 1..2046).
REQ-002 SHALL have parameter RESY, default 11'd48, frame height in pixels (legal 1..2047).
REQ-003 SHALL have parameter IMAX, default 16'd15, iteration limit matching the connected iterator.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port start  input  1  one-cycle request to render one frame.
REQ-007 SHALL have port busy  output  1  high from accepted start until frame_done.
REQ-008 SHALL have port frame_done  output  1  one-cycle pulse when every pixel is written.
REQ-009 SHALL have port next_in  input  1  iterator has consumed xin/yin at this edge.
REQ-010 SHALL have port xin  output 11  and  yin  output 11  coordinate offered to iterator.
REQ-011 SHALL have port next_out  input  1  iterator result valid this cycle.
REQ-012 SHALL have port xout  input 11,  yout  input 11,  i  input 16  result coordinate and count.
REQ-013 SHALL have port wr_en  output 1,  wr_addr  output 22,  wr_data  output 8  framebuffer write port.

Function
REQ-014 SHALL implement states IDLE, ISSUE, DRAIN, DONE.
REQ-015 IDLE: start=1 -> ISSUE, issue coordinate set to (0,0), issued/done counters cleared; start ignored in all other states.
REQ-016 ISSUE: edge with next_in=1 advances coordinate raster order: x+1, at x=RESX-1 wrap x=0 and y+1.
REQ-017 ISSUE: edge with next_in=1 while offering (RESX-1,RESY-1) -> DRAIN; xin/yin become sentinel 11'h7FF/11'h7FF.
REQ-018 In IDLE, DRAIN and DONE xin/yin SHALL hold sentinel 11'h7FF/11'h7FF; next_in in these states changes nothing.
REQ-019 Edge with next_out=1 and xout<RESX and yout<RESY: accepted result; otherwise (sentinel/out-of-range) discarded, no write.
REQ-020 Accepted result SHALL produce wr_en=1 for exactly the following cycle, wr_addr=yout*RESX+xout, wr_data per REQ-029/030 (latency 1 cycle).
REQ-021 Results are accepted in any order and in any state, including ISSUE; out-of-order arrival requires no reordering.
REQ-022 22-bit done counter increments per accepted result; when it reaches RESX*RESY in ISSUE or DRAIN -> DONE.
REQ-023 Counter reaching total while in ISSUE (impossible in correct operation) SHALL still take DONE; excess results after DONE are written but not counted.
REQ-024 DONE: frame_done=1 for one cycle, then IDLE; start in DONE ignored.
REQ-025 busy=1 in ISSUE, DRAIN, DONE; 0 in IDLE.
REQ-026 Simultaneous last issue and last accepted result (RESX*RESY=1 case): DONE taken, sentinel driven.

Reset
REQ-027 rst_n low SHALL asynchronously force IDLE, busy=0, frame_done=0, wr_en=0, wr_addr=0, wr_data=0, xin=yin=11'h7FF, counters=0.
REQ-028 Reset mid-frame SHALL abandon the frame; results arriving after release are discarded only if out of range, otherwise written but not counted until next start clears counters.

Configuration
REQ-029 Without MANDELBROT_SCAN_PALETTE_EN: wr_data = i saturated to 8 bits (i>255 -> 8'hFF).
REQ-030 With MANDELBROT_SCAN_PALETTE_EN: i>=IMAX -> 8'h00; else RGB332 = {i[2:0], i[5:3], i[7:6]}.

Verification
REQ-031 RESX=4,RESY=2, start, next_in held 1 -> xin/yin (0,0),(1,0),(2,0),(3,0),(0,1)..(3,1) on consecutive cycles, then 7FF/7FF.
REQ-032 Feed 8 results in reverse order with i=3 -> wr_addr 7..0, wr_data 8'h03 (no palette), frame_done pulse one cycle after 8th result, busy falls.
REQ-033 next_out with xout=7FF,yout=7FF during DRAIN -> no wr_en, counter unchanged, stays DRAIN.
REQ-034 Palette on, IMAX=15: i=15 -> wr_data 8'h00; i=9 -> 8'h24.
REQ-035 rst_n low after 3 issued pixels -> immediately IDLE, busy=0, xin=7FF; new start restarts at (0,0), frame completes after 8 fresh results.
REQ-036 start pulsed while busy -> ignored, coordinate sequence unaffected.
